// File: rtl/fir_out_decimator.sv
// Decimate, round, shift and saturate FIR samples into a small FIFO stream; 2 edges from in_valid to out_valid.
// Backpressure: out_data/out_valid hold while out_ready=0; pushes into a full FIFO are dropped and flagged.
module fir_out_decimator #(
    parameter int DECIM = 4,
    parameter int SHIFT = 15,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [31:0]              y_in,
    output logic [15:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     sat_flag,
    output logic [15:0]              sat_count,
    output logic                     overflow
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(DEPTH);
    // Half of the shift step; collapses to zero when SHIFT is 0.
    localparam logic [32:0] RND = (33'd1 << SHIFT) >> 1;

    logic [PW-1:0]      phase_q, phase_d;
    logic               s1_vld_q, s1_vld_d;
    logic signed [32:0] s1_dat_q, s1_dat_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic               sat_flag_q, sat_flag_d;
    logic [15:0]        sat_cnt_q, sat_cnt_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        mem_q [DEPTH];

    logic               keep;
    logic signed [32:0] sum;
    logic signed [32:0] rnd;
    logic               sat_hi, sat_lo;
    logic [15:0]        sat_val;
    logic               full, push, pop, wr_en;

    assign keep    = in_valid && (phase_q == '0);
    assign sum     = $signed({y_in[31], y_in}) + $signed(RND);
    assign rnd     = sum >>> SHIFT;

    assign sat_hi  = s1_dat_q > 33'sd32767;
    assign sat_lo  = s1_dat_q < -33'sd32768;
    assign sat_val = sat_hi ? 16'h7FFF : (sat_lo ? 16'h8000 : s1_dat_q[15:0]);

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign push    = s1_vld_q;
    assign pop     = out_valid && out_ready;
    // A pop frees the slot the simultaneous push needs, so full+pop still writes.
    assign wr_en   = push && (!full || pop);

    always_comb begin
        phase_d    = phase_q;
        s1_vld_d   = 1'b0;
        s1_dat_d   = s1_dat_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        sat_flag_d = sat_flag_q;
        sat_cnt_d  = sat_cnt_q;
        ovf_d      = ovf_q;
        if (clear) begin
            phase_d    = '0;
            s1_dat_d   = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            sat_flag_d = 1'b0;
            sat_cnt_d  = '0;
            ovf_d      = 1'b0;
        end else begin
            if (in_valid) begin
                phase_d = (phase_q == PW'(DECIM-1)) ? '0 : phase_q + 1'b1;
            end
            s1_vld_d = keep;
            if (keep) begin
                s1_dat_d = rnd;
            end
            if (push && (sat_hi || sat_lo)) begin
                sat_flag_d = 1'b1;
                if (sat_cnt_q != 16'hFFFF) begin
                    sat_cnt_d = sat_cnt_q + 16'd1;
                end
            end
            if (push && full && !pop) begin
                ovf_d = 1'b1;
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= '0;
            s1_vld_q   <= 1'b0;
            s1_dat_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            sat_flag_q <= 1'b0;
            sat_cnt_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            s1_vld_q   <= s1_vld_d;
            s1_dat_q   <= s1_dat_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            sat_flag_q <= sat_flag_d;
            sat_cnt_q  <= sat_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem_q[wr_ptr_q] <= sat_val;
        end
    end

    assign out_valid = cnt_q != '0;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign level     = cnt_q;
    assign sat_flag  = sat_flag_q;
    assign sat_count = sat_cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench for fir_out_decimator: DECIM=1 and DECIM=4 instances share stimulus,
// each checked against a queue of expected conditioned samples.
module tb_fir_out_decimator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clear, in_valid, rdy1, rdy4;
    logic [31:0] y_in;
    logic [15:0] od1, od4, sc1, sc4;
    logic        ov1, ov4, sf1, sf4, of1, of4;
    logic [2:0]  lv1, lv4;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] q1[$];
    logic [15:0] q4[$];
    bit          chk4_en = 1'b0;
    logic [15:0] e1, e4;

    fir_out_decimator #(.DECIM(1), .SHIFT(15), .DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .y_in(y_in),
        .out_data(od1), .out_valid(ov1), .out_ready(rdy1), .level(lv1),
        .sat_flag(sf1), .sat_count(sc1), .overflow(of1)
    );

    fir_out_decimator #(.DECIM(4), .SHIFT(15), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .y_in(y_in),
        .out_data(od4), .out_valid(ov4), .out_ready(rdy4), .level(lv4),
        .sat_flag(sf4), .sat_count(sc4), .overflow(of4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [31:0] y);
        in_valid = 1'b1;
        y_in     = y;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"},  od1, 0);
        chk({tag, "_valid"}, ov1, 0);
        chk({tag, "_level"}, lv1, 0);
        chk({tag, "_sflag"}, sf1, 0);
        chk({tag, "_scnt"},  sc1, 0);
        chk({tag, "_ovf"},   of1, 0);
    endtask

    // Scoreboards: every accepted beat must match the oldest expected value.
    always @(negedge clk) begin
        if (rst_n && ov1 && rdy1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_beat", od1, 32'hDEAD_0000);
            end else begin
                e1 = q1.pop_front();
                chk("dut1_stream", od1, e1);
            end
        end
        if (rst_n && chk4_en && ov4 && rdy4) begin
            if (q4.size() == 0) begin
                chk("dut4_unexpected_beat", od4, 32'hDEAD_0000);
            end else begin
                e4 = q4.pop_front();
                chk("dut4_stream", od4, e4);
            end
        end
    end

    logic [31:0] rin  [4] = '{32'h0000_4000, 32'h0000_3FFF, 32'hFFFF_C000, 32'hFFFF_BFFF};
    logic [15:0] rexp [4] = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF};

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; y_in = '0; rdy1 = 1'b1; rdy4 = 1'b1;
        #3;
        check_zero("reset");
        tick();
        rst_n = 1'b1;

        // Rounding, with two-edge latency
        for (int i = 0; i < 4; i++) begin
            q1.push_back(rexp[i]);
            pulse(rin[i]);
            chk("round_lat_e0", ov1, 0);
            tick();
            chk("round_valid_e1", ov1, 1);
            chk("round_data_e1", od1, rexp[i]);
            tick();
        end
        chk("round_no_sat", sf1, 0);

        // Saturation, back-to-back samples
        q1.push_back(16'h7FFF);
        pulse(32'h7FFF_FFFF);
        q1.push_back(16'h8000);
        pulse(32'h8000_0000);
        tick(); tick();
        chk("sat_flag", sf1, 1);
        chk("sat_count", sc1, 2);
        q1.push_back(16'h7FFF);
        pulse(32'h3FFF_8000);
        tick(); tick();
        chk("sat_count_exact_max", sc1, 2);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        q1.delete(); q4.delete();
        chk("clear_sflag", sf1, 0);
        chk("clear_scnt", sc1, 0);

        // Decimation by 4 with idle gaps
        chk4_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 1 || k == 5) q4.push_back(16'(k));
            q1.push_back(16'(k));
            pulse(32'(k) << 15);
            tick(); tick();
        end
        tick();
        chk("decim_all_seen", q4.size(), 0);
        chk4_en = 1'b0;

        // Backpressure and overflow
        rdy1 = 1'b0;
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            y_in = 32'(k) << 15;
            if (k <= 4) q1.push_back(16'(k));
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("bp_level_full", lv1, 4);
        chk("bp_overflow", of1, 1);
        chk("bp_valid", ov1, 1);
        chk("bp_head", od1, 1);
        tick(); tick();
        chk("bp_head_hold", od1, 1);
        rdy1 = 1'b1;
        repeat (6) tick();
        chk("bp_level_drained", lv1, 0);
        chk("bp_queue_drained", q1.size(), 0);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        q1.delete();

        // Push and pop in the same edge while full
        rdy1 = 1'b0;
        in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            y_in = 32'(k) << 15;
            q1.push_back(16'(k));
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("fp_level_full", lv1, 4);
        chk("fp_no_ovf_yet", of1, 0);
        q1.push_back(16'd9);
        pulse(32'd9 << 15);
        rdy1 = 1'b1;
        tick();
        rdy1 = 1'b0;
        chk("fp_level_same", lv1, 4);
        chk("fp_no_ovf", of1, 0);
        chk("fp_new_head", od1, 2);
        rdy1 = 1'b1;
        repeat (6) tick();
        chk("fp_level_drained", lv1, 0);
        chk("fp_queue_drained", q1.size(), 0);

        // Synchronous clear mid-operation
        rdy1 = 1'b0;
        in_valid = 1'b1;
        y_in = 32'h7FFF_FFFF;
        repeat (4) tick();
        in_valid = 1'b0;
        chk("clr_pre_level", lv1, 3);
        chk("clr_pre_sflag", sf1, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_zero("clr");
        tick();
        chk("clr_stage1_dropped", lv1, 0);
        rdy1 = 1'b1;
        q1.push_back(16'd3);
        pulse(32'd3 << 15);
        chk("clr_lat_e0", ov1, 0);
        tick();
        chk("clr_lat_valid", ov1, 1);
        chk("clr_lat_data", od1, 3);
        tick();

        // Asynchronous reset between edges
        rdy1 = 1'b0;
        in_valid = 1'b1;
        y_in = 32'h7FFF_FFFF;
        repeat (4) tick();
        in_valid = 1'b0;
        chk("rst_pre_level", lv1, 3);
        #3 rst_n = 1'b0;
        #1 check_zero("arst");
        #1 rst_n = 1'b1;
        q1.delete(); q4.delete();
        tick();
        chk("arst_stage1_dropped", lv1, 0);
        chk("arst_dut4_level", lv4, 0);
        chk4_en = 1'b1;
        rdy1 = 1'b1;
        q1.push_back(16'd7);
        q4.push_back(16'd7);
        pulse(32'd7 << 15);
        chk("arst_lat_e0", ov1, 0);
        tick();
        chk("arst_lat_valid", ov1, 1);
        chk("arst_lat_data", od1, 7);
        chk("arst_phase0_valid", ov4, 1);
        chk("arst_phase0_data", od4, 7);
        tick(); tick();
        chk("final_q1_empty", q1.size(), 0);
        chk("final_q4_empty", q4.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
